// File: rtl/simt_reconv_stack.sv
// simt_reconv_stack: per-warp SIMT reconvergence stacks.
// Each warp owns a LIFO of {pc, mask, rpc} entries and a depth counter.
//
// Supported operations:
//   PUSH    push one entry.
//   POP     drop the top entry; storage is not cleared.
//   JUMP    rewrite the pc field of the top entry.
//   FLUSH   empty the stack.
//   BRANCH  push two entries over two cycles: the not-taken entry first,
//           then the taken entry, which ends on top.
//
// Ports:
//   clk, rst_n (async, active-low)
//   op_valid/op_ready handshake; op_warp, op_code,
//     push_pc/push_mask/push_rpc, alt_pc/alt_mask
//   rd_warp selects the stack reported on top_valid/top_pc/top_mask/
//     top_rpc/top_depth; these are registered, one cycle of latency.
//   err is a sticky error vector: bit5 overflow, bit6 underflow,
//     bit7 invalid op. err_clr clears it.
module simt_reconv_stack #(
  parameter int NUM_WARPS = 4,
  parameter int DEPTH     = 16,
  parameter int THREADS   = 32,
  parameter int PC_W      = 32,
  localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int DW = $clog2(DEPTH + 1),
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [WW-1:0]      op_warp,
  input  logic [2:0]         op_code,
  input  logic [PC_W-1:0]    push_pc,
  input  logic [THREADS-1:0] push_mask,
  input  logic [PC_W-1:0]    alt_pc,
  input  logic [THREADS-1:0] alt_mask,
  input  logic [PC_W-1:0]    push_rpc,
  input  logic [WW-1:0]      rd_warp,
  output logic               top_valid,
  output logic [PC_W-1:0]    top_pc,
  output logic [THREADS-1:0] top_mask,
  output logic [PC_W-1:0]    top_rpc,
  output logic [DW-1:0]      top_depth,
  output logic [31:0]        err,
  input  logic               err_clr
);

  typedef enum logic [2:0] {
    OP_BRANCH = 3'd0,
    OP_JUMP   = 3'd1,
    OP_FLUSH  = 3'd2,
    OP_POP    = 3'd3,
    OP_PUSH   = 3'd4
  } branch_op_t;

  typedef enum logic {S_IDLE, S_BR2} state_t;

  localparam logic [DW-1:0] DEPTH_D = DW'(DEPTH);

  state_t state, state_n;

  logic [PC_W-1:0]    pc_mem   [NUM_WARPS][DEPTH];
  logic [THREADS-1:0] mask_mem [NUM_WARPS][DEPTH];
  logic [PC_W-1:0]    rpc_mem  [NUM_WARPS][DEPTH];
  logic [DW-1:0]      depth_q  [NUM_WARPS];

  // Taken half of a BRANCH, held for the second push.
  logic [PC_W-1:0]    br_pc, br_rpc;
  logic [THREADS-1:0] br_mask;
  logic [WW-1:0]      br_warp;

  logic [2:0] err_q, err_set;  // {invalid, underflow, overflow}

  logic               lat_en, wr_pc_en, wr_all_en, dep_en;
  logic [WW-1:0]      tgt_warp;
  logic [DW-1:0]      cur_d, cur_dm1, dep_val;
  logic [IW-1:0]      wr_idx;
  logic [PC_W-1:0]    wr_pc, wr_rpc;
  logic [THREADS-1:0] wr_mask;

  assign op_ready = (state == S_IDLE);
  assign err      = {24'd0, err_q, 5'd0};
  assign tgt_warp = (state == S_BR2) ? br_warp : op_warp;
  assign cur_d    = depth_q[tgt_warp];
  assign cur_dm1  = cur_d - DW'(1);

  always_comb begin
    state_n   = state;
    lat_en    = 1'b0;
    wr_pc_en  = 1'b0;
    wr_all_en = 1'b0;
    wr_idx    = cur_d[IW-1:0];
    wr_pc     = push_pc;
    wr_mask   = push_mask;
    wr_rpc    = push_rpc;
    dep_en    = 1'b0;
    dep_val   = cur_d;
    err_set   = 3'b000;
    if (state == S_BR2) begin
      // Second half of BRANCH; any op offered this cycle is ignored.
      wr_pc_en  = 1'b1;
      wr_all_en = 1'b1;
      wr_pc     = br_pc;
      wr_mask   = br_mask;
      wr_rpc    = br_rpc;
      dep_en    = 1'b1;
      dep_val   = cur_d + DW'(1);
      state_n   = S_IDLE;
    end else if (op_valid) begin
      case (op_code)
        OP_PUSH: begin
          if (cur_d == DEPTH_D) begin
            err_set[0] = 1'b1;
          end else begin
            wr_pc_en  = 1'b1;
            wr_all_en = 1'b1;
            dep_en    = 1'b1;
            dep_val   = cur_d + DW'(1);
          end
        end
        OP_POP: begin
          if (cur_d == '0) begin
            err_set[1] = 1'b1;
          end else begin
            dep_en  = 1'b1;
            dep_val = cur_dm1;
          end
        end
        OP_JUMP: begin
          if (cur_d == '0) begin
            err_set[1] = 1'b1;
          end else begin
            wr_pc_en = 1'b1;
            wr_idx   = cur_dm1[IW-1:0];
          end
        end
        OP_FLUSH: begin
          dep_en  = 1'b1;
          dep_val = '0;
        end
        OP_BRANCH: begin
          // Both entries must fit before the first one is written.
          if (int'(cur_d) + 2 > DEPTH) begin
            err_set[0] = 1'b1;
          end else begin
            wr_pc_en  = 1'b1;
            wr_all_en = 1'b1;
            wr_pc     = alt_pc;
            wr_mask   = alt_mask;
            dep_en    = 1'b1;
            dep_val   = cur_d + DW'(1);
            lat_en    = 1'b1;
            state_n   = S_BR2;
          end
        end
        default: err_set[2] = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      for (int w = 0; w < NUM_WARPS; w++) depth_q[w] <= '0;
      err_q <= '0;
    end else begin
      state <= state_n;
      if (dep_en) depth_q[tgt_warp] <= dep_val;
      err_q <= err_clr ? err_set : (err_q | err_set);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_pc_en)  pc_mem[tgt_warp][wr_idx]   <= wr_pc;
    if (wr_all_en) mask_mem[tgt_warp][wr_idx] <= wr_mask;
    if (wr_all_en) rpc_mem[tgt_warp][wr_idx]  <= wr_rpc;
    if (lat_en) begin
      br_pc   <= push_pc;
      br_mask <= push_mask;
      br_rpc  <= push_rpc;
      br_warp <= op_warp;
    end
  end

  // Post-update view of rd_warp, with same-cycle writes forwarded.
  logic [DW-1:0]      rd_d_n, rd_dm1;
  logic [IW-1:0]      rd_idx;
  logic               hit;
  logic [PC_W-1:0]    rd_pc, rd_rpc;
  logic [THREADS-1:0] rd_mask;

  assign rd_d_n  = (dep_en && tgt_warp == rd_warp) ? dep_val : depth_q[rd_warp];
  assign rd_dm1  = rd_d_n - DW'(1);
  assign rd_idx  = rd_dm1[IW-1:0];
  assign hit     = (tgt_warp == rd_warp) && (wr_idx == rd_idx);
  assign rd_pc   = (wr_pc_en && hit)  ? wr_pc   : pc_mem[rd_warp][rd_idx];
  assign rd_mask = (wr_all_en && hit) ? wr_mask : mask_mem[rd_warp][rd_idx];
  assign rd_rpc  = (wr_all_en && hit) ? wr_rpc  : rpc_mem[rd_warp][rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_valid <= 1'b0;
      top_pc    <= '0;
      top_mask  <= '0;
      top_rpc   <= '0;
      top_depth <= '0;
    end else begin
      top_valid <= (rd_d_n != '0);
      top_depth <= rd_d_n;
      top_pc    <= (rd_d_n != '0) ? rd_pc   : '0;
      top_mask  <= (rd_d_n != '0) ? rd_mask : '0;
      top_rpc   <= (rd_d_n != '0) ? rd_rpc  : '0;
    end
  end

endmodule

// File: tb/tb_simt_reconv_stack.sv
// Directed testbench for simt_reconv_stack (default parameters).
module tb_simt_reconv_stack;

  localparam logic [2:0] BRANCH = 3'd0, JUMP = 3'd1, FLUSH = 3'd2,
                         POP = 3'd3, PUSH = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n, op_valid, op_ready, err_clr, top_valid;
  logic [1:0]  op_warp, rd_warp;
  logic [2:0]  op_code;
  logic [31:0] push_pc, push_mask, alt_pc, alt_mask, push_rpc;
  logic [31:0] top_pc, top_mask, top_rpc, err;
  logic [4:0]  top_depth;

  int n_vec = 0;
  int n_err = 0;

  simt_reconv_stack dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_warp(op_warp), .op_code(op_code), .push_pc(push_pc),
    .push_mask(push_mask), .alt_pc(alt_pc), .alt_mask(alt_mask),
    .push_rpc(push_rpc), .rd_warp(rd_warp), .top_valid(top_valid),
    .top_pc(top_pc), .top_mask(top_mask), .top_rpc(top_rpc),
    .top_depth(top_depth), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the op is accepted on the next posedge and the
  // task returns at the following negedge, when top_* reflect it.
  task automatic do_op(input logic [1:0] w, input logic [2:0] c,
                       input logic [31:0] pc, input logic [31:0] mask,
                       input logic [31:0] rpc);
    op_valid  = 1'b1;
    op_warp   = w;
    op_code   = c;
    push_pc   = pc;
    push_mask = mask;
    push_rpc  = rpc;
    @(negedge clk);
    op_valid  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; op_valid = 1'b0; err_clr = 1'b0; op_warp = '0;
    op_code = '0; push_pc = '0; push_mask = '0; alt_pc = '0;
    alt_mask = '0; push_rpc = '0; rd_warp = '0;
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_ready", op_ready, 1);
    check_eq("rst_valid", top_valid, 0);
    check_eq("rst_depth", top_depth, 0);
    check_eq("rst_pc", top_pc, 0);
    check_eq("rst_err", err, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single push on warp1.
    rd_warp = 2'd1;
    do_op(2'd1, PUSH, 32'h100, 32'hFFFF_FFFF, 32'h200);
    check_eq("push_valid", top_valid, 1);
    check_eq("push_pc", top_pc, 32'h100);
    check_eq("push_mask", top_mask, 32'hFFFF_FFFF);
    check_eq("push_rpc", top_rpc, 32'h200);
    check_eq("push_depth", top_depth, 1);
    rd_warp = 2'd0;
    @(negedge clk);
    check_eq("w0_empty_valid", top_valid, 0);
    check_eq("w0_empty_pc", top_pc, 0);

    // BRANCH on warp0, with a competing op offered during BR2.
    alt_pc = 32'h80; alt_mask = 32'hFFFF_0000;
    op_valid = 1'b1; op_warp = 2'd0; op_code = BRANCH;
    push_pc = 32'h40; push_mask = 32'h0000_FFFF; push_rpc = 32'hC0;
    @(negedge clk);
    check_eq("br2_ready", op_ready, 0);
    check_eq("br1_depth", top_depth, 1);
    check_eq("br1_pc", top_pc, 32'h80);
    op_code = PUSH; push_pc = 32'h999;
    @(negedge clk);
    op_valid = 1'b0;
    check_eq("br_ready_back", op_ready, 1);
    check_eq("br_depth", top_depth, 2);
    check_eq("br_pc", top_pc, 32'h40);
    check_eq("br_mask", top_mask, 32'h0000_FFFF);
    check_eq("br_rpc", top_rpc, 32'hC0);
    @(negedge clk);
    check_eq("br_ignored_depth", top_depth, 2);
    do_op(2'd0, POP, 0, 0, 0);
    check_eq("pop_pc", top_pc, 32'h80);
    check_eq("pop_mask", top_mask, 32'hFFFF_0000);
    check_eq("pop_rpc", top_rpc, 32'hC0);
    check_eq("pop_depth", top_depth, 1);

    // Fill warp2, then overflow via PUSH and BRANCH.
    rd_warp = 2'd2;
    for (int i = 0; i < 16; i++) do_op(2'd2, PUSH, 32'h1000 + i, i, 0);
    check_eq("full_depth", top_depth, 16);
    check_eq("full_pc", top_pc, 32'h100F);
    check_eq("full_err", err, 0);
    do_op(2'd2, PUSH, 32'h2000, 0, 0);
    check_eq("ovf_err", err, 32'h20);
    check_eq("ovf_depth", top_depth, 16);
    check_eq("ovf_pc", top_pc, 32'h100F);
    do_op(2'd2, POP, 0, 0, 0);
    check_eq("d15_depth", top_depth, 15);
    do_op(2'd2, BRANCH, 32'h3000, 32'h1, 32'h3100);
    check_eq("brovf_ready", op_ready, 1);
    check_eq("brovf_err", err, 32'h20);
    @(negedge clk);
    check_eq("brovf_depth", top_depth, 15);
    check_eq("brovf_pc", top_pc, 32'h100E);

    // Underflow with simultaneous clear, then invalid op.
    rd_warp = 2'd3;
    err_clr = 1'b1;
    do_op(2'd3, POP, 0, 0, 0);
    err_clr = 1'b0;
    check_eq("udf_err", err, 32'h40);
    check_eq("udf_valid", top_valid, 0);
    check_eq("udf_depth", top_depth, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_eq("clr_err", err, 0);
    do_op(2'd3, 3'd5, 32'h77, 32'h1, 32'h1);
    check_eq("inv_err", err, 32'h80);
    check_eq("inv_depth", top_depth, 0);
    do_op(2'd3, JUMP, 32'h88, 0, 0);
    check_eq("jmp_udf_err", err, 32'hC0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;

    // JUMP and FLUSH on warp1.
    rd_warp = 2'd1;
    do_op(2'd1, PUSH, 32'h110, 32'hF0, 32'h210);
    do_op(2'd1, PUSH, 32'h120, 32'h0F, 32'h300);
    check_eq("d3_depth", top_depth, 3);
    do_op(2'd1, JUMP, 32'h500, 32'h0, 32'h0);
    check_eq("jmp_pc", top_pc, 32'h500);
    check_eq("jmp_depth", top_depth, 3);
    check_eq("jmp_mask", top_mask, 32'h0F);
    check_eq("jmp_rpc", top_rpc, 32'h300);
    do_op(2'd1, FLUSH, 0, 0, 0);
    check_eq("fl_valid", top_valid, 0);
    check_eq("fl_depth", top_depth, 0);
    check_eq("fl_pc", top_pc, 0);
    do_op(2'd1, FLUSH, 0, 0, 0);
    check_eq("fl_empty_err", err, 0);
    rd_warp = 2'd2;
    @(negedge clk);
    check_eq("iso_depth", top_depth, 15);
    check_eq("iso_pc", top_pc, 32'h100E);

    // Reset while in BR2.
    rd_warp = 2'd0;
    alt_pc = 32'hA0; alt_mask = 32'h3;
    op_valid = 1'b1; op_warp = 2'd0; op_code = BRANCH;
    push_pc = 32'h60; push_mask = 32'hC; push_rpc = 32'hE0;
    @(posedge clk);
    #1 op_valid = 1'b0;
    check_eq("rbr_ready", op_ready, 0);
    check_eq("rbr_depth", top_depth, 2);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rbr_rst_ready", op_ready, 1);
    check_eq("rbr_rst_depth", top_depth, 0);
    check_eq("rbr_rst_valid", top_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("rbr_post_depth", top_depth, 0);
    check_eq("rbr_post_valid", top_valid, 0);
    check_eq("rbr_post_ready", op_ready, 1);
    rd_warp = 2'd2;
    @(negedge clk);
    check_eq("rbr_w2_depth", top_depth, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
